// File: rtl/putout_port.sv
// putout_port: transmit-side output port of the stack processor.
// Words written by the putout instruction are queued in a small circular FIFO.
// The FIFO drains to an external consumer over a valid/ready handshake.
// Optional feature macro: PUTOUT_OVERFLOW_EN. When it is defined, overflow is
// a sticky flag for dropped writes. Otherwise overflow is tied to 0.
//
// Handshake semantics:
//   A word transfers on a rising CLK edge where out_valid && out_ready.
//   While out_valid is high and out_ready is low, out_data is held stable.
//   out_valid depends only on registered state, never on out_ready.
//   A write is accepted when wr_en is high and the FIFO is not FULL.
//   A write is also accepted when FULL if a read completes in that same cycle.
//   The core must stall putout while full is high.
module putout_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] last_written,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [OW-1:0]    occ, occ_next;
  logic             rd_fire, wr_fire;

  // Outputs are decoded from registered state only.
  assign out_valid = (state != S_EMPTY);
  assign full      = (state == S_FULL);
  assign out_data  = mem[rd_ptr];
  assign state_dbg = state;

  // The read frees a slot in the same cycle, so a FULL FIFO can still take a write.
  assign rd_fire = out_valid & out_ready;
  assign wr_fire = wr_en & (~full | rd_fire);

  // Port state register.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= S_EMPTY;
      occ   <= '0;
    end else begin
      state <= state_next;
      occ   <= occ_next;
    end
  end

  // Next occupancy and next port state.
  always_comb begin
    occ_next   = occ;
    state_next = state;
    if (wr_fire && !rd_fire) begin
      occ_next = occ + OW'(1);
    end else if (rd_fire && !wr_fire) begin
      occ_next = occ - OW'(1);
    end
    case (state)
      S_EMPTY: begin
        if (wr_fire) state_next = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (wr_fire && !rd_fire && occ == OW'(DEPTH - 1)) state_next = S_FULL;
        else if (rd_fire && !wr_fire && occ == OW'(1))    state_next = S_EMPTY;
      end
      S_FULL: begin
        if (rd_fire && !wr_fire) state_next = S_PARTIAL;
      end
      default: state_next = S_EMPTY;
    endcase
  end

  // Storage, pointers and the last-written register.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_written <= '0;
    end else begin
      if (wr_fire) begin
        mem[wr_ptr]  <= wr_data;
        wr_ptr       <= wr_ptr + AW'(1);
        last_written <= wr_data;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Delivered-word counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      out_count <= '0;
    end else if (rd_fire) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

`ifdef PUTOUT_OVERFLOW_EN
  logic overflow_q;

  // Sticky flag for writes dropped while FULL with no read to make room.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (wr_en && full && !rd_fire) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_putout_port.sv
// Bench for putout_port: directed vectors with a queue of expected output words.
module tb_putout_port;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

`ifdef PUTOUT_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [WIDTH-1:0] last_written;
  logic [CNT_W-1:0] out_count;
  logic             overflow;
  logic [1:0]       state_dbg;

  logic [WIDTH-1:0] exp_q[$];
  int               model_occ;
  int               checks;
  int               failures;

  putout_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .last_written(last_written),
    .out_count(out_count), .overflow(overflow), .state_dbg(state_dbg)
  );

  // Clock and reset.
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle; the bench's own occupancy model decides what the port accepts.
  task automatic step(input logic we, input logic [WIDTH-1:0] d, input logic rdy);
    logic rd;
    logic acc;
    wr_en     = we;
    wr_data   = d;
    out_ready = rdy;
    rd  = (model_occ > 0) && rdy;
    acc = we && ((model_occ < DEPTH) || rd);
    if (acc) exp_q.push_back(d);
    model_occ = model_occ + (acc ? 1 : 0) - (rd ? 1 : 0);
    @(posedge CLK);
    #1;
    wr_en     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    wr_en     = 1'b1;
    wr_data   = 16'hBEEF;
    out_ready = 1'b0;
    @(posedge CLK);
    #1;
    reset     = 1'b1;
    wr_en     = 1'b0;
    exp_q.delete();
    model_occ = 0;
  endtask

  // Monitor: compares each delivered word against the head of the expected queue.
  always @(negedge CLK) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_data_unexpected: got %0d expected no word", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL out_data: got %0d expected %0d", out_data, e);
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0; model_occ = 0;
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
    #2;
    do_reset();
    do_reset();
    check("rst_out_valid", CNT_W'(out_valid), 0);
    check("rst_full", CNT_W'(full), 0);
    check("rst_out_count", out_count, 0);
    check("rst_last_written", CNT_W'(last_written), 0);
    check("rst_out_data", CNT_W'(out_data), 0);
    check("rst_overflow", CNT_W'(overflow), 0);

    // Two writes with the consumer stalled.
    step(1'b1, 16'd3, 1'b0);
    step(1'b1, 16'd4, 1'b0);
    check("t1_out_valid", CNT_W'(out_valid), 1);
    check("t1_out_data", CNT_W'(out_data), 3);
    check("t1_last_written", CNT_W'(last_written), 4);
    check("t1_out_count", out_count, 0);

    // Drain them.
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check("t2_out_count", out_count, 2);
    check("t2_out_valid", CNT_W'(out_valid), 0);
    check("t2_full", CNT_W'(full), 0);

    // Fill to FULL, fifth write dropped.
    for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0);
    check("t3_full", CNT_W'(full), 1);
    check("t3_overflow_before", CNT_W'(overflow), 0);
    step(1'b1, 16'd5, 1'b0);
    check("t3_full_after_drop", CNT_W'(full), 1);
    check("t3_overflow", CNT_W'(overflow), CNT_W'(OVF_ON));
    check("t3_last_written", CNT_W'(last_written), 4);

    // Write and read together while FULL.
    step(1'b1, 16'd9, 1'b1);
    check("t4_full", CNT_W'(full), 1);
    check("t4_out_count", out_count, 3);
    check("t4_last_written", CNT_W'(last_written), 9);
    check("t4_overflow", CNT_W'(overflow), CNT_W'(OVF_ON));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    check("t4_drained", CNT_W'(out_valid), 0);
    check("t4_count_after", out_count, 7);

    // Streaming 0..15 with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, WIDTH'(i), 1'b1);
      check("t5_full_never", CNT_W'(full), 0);
    end
    step(1'b0, '0, 1'b1);
    check("t5_out_count", out_count, 23);
    check("t5_out_valid", CNT_W'(out_valid), 0);

    // Reset in the middle of a drain.
    step(1'b1, 16'd10, 1'b0);
    step(1'b1, 16'd11, 1'b0);
    step(1'b1, 16'd12, 1'b0);
    step(1'b0, '0, 1'b1);
    check("t6_pre_count", out_count, 24);
    do_reset();
    check("t6_out_valid", CNT_W'(out_valid), 0);
    check("t6_full", CNT_W'(full), 0);
    check("t6_out_count", out_count, 0);
    check("t6_last_written", CNT_W'(last_written), 0);
    check("t6_out_data", CNT_W'(out_data), 0);
    check("t6_overflow", CNT_W'(overflow), 0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check("t6_idle_valid", CNT_W'(out_valid), 0);
    step(1'b1, 16'd7, 1'b0);
    check("t6_new_data", CNT_W'(out_data), 7);
    step(1'b0, '0, 1'b1);
    check("t6_new_count", out_count, 1);

    check("queue_empty", CNT_W'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/putout_port.md
# putout_port

Output port for the stack processor, carrying the `putout` instruction. It is the transmit-side counterpart of the `getin`/`getin2` input ports. The core pushes 16-bit words popped from the top of stack into a small FIFO. The FIFO drains to an external consumer over a valid/ready handshake. The port also keeps a delivered-word counter and a last-written register for bench observation.

## Interface
- `WIDTH`, 16: data word width (matches stack word).
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 32: width of the delivered-word counter.

- `CLK`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on `CLK` rising edge.
- `wr_en`  in  1  core writes `wr_data` this cycle (`putout` executing).
- `wr_data`  in  WIDTH  word popped from top of stack.
- `full`  out  1  FIFO holds DEPTH words; core must stall `putout`.
- `out_valid`  out  1  `out_data` holds a word for the consumer.
- `out_data`  out  WIDTH  head-of-FIFO word.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `last_written`  out  WIDTH  most recent accepted `wr_data`.
- `out_count`  out  CNT_W  number of completed output handshakes.
- `overflow`  out  1  sticky write-while-full flag (see Configuration).

## Operation
- Circular FIFO with read pointer, write pointer and occupancy counter. The counter is log2(DEPTH)+1 bits; the pointers wrap modulo DEPTH.
- Port state follows occupancy: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY→PARTIAL on write without read.
  - PARTIAL→FULL when a write without a read brings occupancy to DEPTH.
  - FULL→PARTIAL on read without write.
  - PARTIAL→EMPTY when a read without a write brings occupancy to 0.
- Write accepted when `wr_en` and (not FULL, or a read completes in the same cycle).
  - An accepted write stores `wr_data` at the write pointer, advances the pointer and updates `last_written`.
- Read (handshake) occurs when `out_valid` and `out_ready`. It advances the read pointer and increments `out_count`, which wraps at 2^CNT_W.
- Simultaneous accepted write and read leaves occupancy unchanged.
  - When EMPTY, no read is possible, so a write and `out_ready` in the same cycle results in a write only.
  - When FULL, the write is accepted because the read frees a slot that same cycle.
- Write while FULL with no read: word dropped; no state change except `overflow` handling.
- `out_valid` = occupancy ≠ 0. `out_data` = FIFO entry at the read pointer; it is held stable while `out_valid` && !`out_ready`.
- `full` = occupancy == DEPTH.
- Reset values (`reset` low at an edge):
  - pointers = 0, occupancy = 0, `out_valid` = 0, `full` = 0.
  - `out_count` = 0, `last_written` = 0, `overflow` = 0.
  - `out_data` = 0; FIFO storage is cleared.
- Reset mid-transfer discards all queued words. A `wr_en` in the reset cycle is ignored.

## Timing
- Write to visible: a word written at edge N appears with `out_valid` = 1 after edge N, i.e. it is presentable in cycle N+1.
- A full-to-not-full transition is visible the cycle after the read edge.
- Back-to-back: one write and one read per cycle sustained indefinitely at any occupancy 1..DEPTH.
- All outputs are registered or decoded from registers only. There is no combinational path from `wr_en` or `out_ready` to any output.

## Configuration
- `PUTOUT_OVERFLOW_EN` defined:
  - `overflow` sets on any dropped write (`wr_en`, FULL, no read).
  - It stays set until reset.
- Not defined:
  - `overflow` is tied 0 and the sticky logic is absent.
  - Dropped writes are silent.

## Test plan
- Reset, then write 3, write 4 with `out_ready` = 0 → `out_valid` = 1, `out_data` = 3, `last_written` = 4, `out_count` = 0.
- Raise `out_ready` for 2 cycles → `out_data` 3 then 4, `out_count` = 2, `out_valid` = 0, `full` = 0.
- DEPTH = 4, `out_ready` = 0, write 1,2,3,4,5 → `full` = 1 after 4th write, 5 dropped, `overflow` = 1 (macro on) or 0 (macro off). Drain yields 1,2,3,4.
- FULL with `wr_en` = 1 (data 9) and `out_ready` = 1 same cycle → occupancy stays 4, `out_count` += 1, 9 is delivered last, `overflow` unchanged.
- Continuous write of 0..15 with `out_ready` = 1 → 16 words delivered in order, `full` never asserted, pointers wrap 4 times, `out_count` = 16.
- Write 3 words, assert `reset` = 0 for one edge mid-drain → all outputs return to reset values, no further `out_valid` until a new write.
